parity_stream_checker: RTL and testbench

//   Parametrised, sequential successor to the combinational 4-input XOR block.

---
 rtl/parity_stream_checker.sv | 135 +++++++++++++
 tb/tb_parity_stream_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_checker.sv
// parity_stream_checker
//   Accumulates XOR parity over a frame of WIDTH-bit words arriving on a
//   valid/ready stream, in even or odd mode. The result is compared with the
//   expected parity bit carried on the last beat. A result record is then
//   held on a second valid/ready port until it is consumed.
//
//   Handshake: a transfer happens on a posedge where valid && ready are both
//   high. A producer holds its payload stable while valid && !ready. Ready
//   never depends on the valid input of the same port.
//
//   Overflow: a word that arrives when count already equals MAX_WORDS sets the
//   overflow flag and is not accumulated. The count saturates at MAX_WORDS. If
//   that word is also the last one, the frame closes at once. Otherwise the
//   remaining words are drained until the last beat arrives.
module parity_stream_checker #(
  parameter int WIDTH     = 4,
  parameter int MAX_WORDS = 16,
  localparam int CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_par,
  input  logic             odd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_err,
  output logic             out_ovf,
  output logic [CW-1:0]    out_count,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACC   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  logic [1:0]    state;
  logic          acc;
  logic          mode;
  logic          par_q;
  logic          ovf;
  logic [CW-1:0] count;
  logic          beat;
  logic          word_par;
  logic          calc_par;

  // Input ready and word parity are pure functions of the current state and data.
  always_comb begin
    in_ready = rst && (state != HOLD);
    beat     = in_valid && in_ready;
    word_par = ^in_data;
    calc_par = acc ^ mode;
  end

  // Frame FSM and accumulator. Reset discards any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= 1'b0;
      mode  <= 1'b0;
      par_q <= 1'b0;
      ovf   <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            acc   <= word_par;
            count <= ONE_CNT;
            mode  <= odd_mode;
            ovf   <= 1'b0;
            if (in_last) begin
              par_q <= in_par;
              state <= HOLD;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (beat) begin
            if (count == MAX_CNT) begin
              // One word too many: flag it and do not accumulate it.
              ovf <= 1'b1;
              if (in_last) begin
                par_q <= in_par;
                state <= HOLD;
              end else begin
                state <= DRAIN;
              end
            end else begin
              acc   <= acc ^ word_par;
              count <= count + ONE_CNT;
              if (in_last) begin
                par_q <= in_par;
                state <= HOLD;
              end
            end
          end
        end
        DRAIN: begin
          if (beat && in_last) begin
            par_q <= in_par;
            state <= HOLD;
          end
        end
        default: begin
          if (out_ready) begin
            ovf   <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Result record. Parity and error are only shown while the record is valid.
  always_comb begin
    out_valid  = (state == HOLD);
    out_parity = out_valid && calc_par;
    out_err    = out_valid && (ovf || (calc_par != par_q));
    out_ovf    = ovf;
    out_count  = count;
    state_dbg  = state;
  end

endmodule

// File: tb/tb_parity_stream_checker.sv
// tb_parity_stream_checker
//   Directed bench for parity_stream_checker with WIDTH=4 and MAX_WORDS=4.
//   All expected values are hand-computed constants or the parity of the
//   stimulus word.
module tb_parity_stream_checker;

  localparam int WIDTH     = 4;
  localparam int MAX_WORDS = 4;
  localparam int CW        = $clog2(MAX_WORDS + 1);
  localparam int TMO       = 50;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_par;
  logic             odd_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic             out_err;
  logic             out_ovf;
  logic [CW-1:0]    out_count;
  logic [1:0]       state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  parity_stream_checker #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_par     (in_par),
    .odd_mode   (odd_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_parity (out_parity),
    .out_err    (out_err),
    .out_ovf    (out_ovf),
    .out_count  (out_count),
    .state_dbg  (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: one accepted beat. Inputs change on the negedge and the beat
  // lands on the following posedge once in_ready is seen high.
  task automatic send_beat(input logic [WIDTH-1:0] d, input logic last,
                           input logic par, input logic odd);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_par   = par;
    odd_mode = odd;
    #1;
    while (!in_ready && n < TMO) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("beat_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for a result, compare it, then consume it.
  task automatic expect_result(input string tag, input logic par, input logic err,
                               input logic ovf, input logic [CW-1:0] cnt);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"},  32'(out_valid),  32'd1);
    check({tag, "_parity"}, 32'(out_parity), 32'(par));
    check({tag, "_err"},    32'(out_err),    32'(err));
    check({tag, "_ovf"},    32'(out_ovf),    32'(ovf));
    check({tag, "_count"},  32'(out_count),  32'(cnt));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic             hold_par;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_par    = 1'b0;
    odd_mode  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),   32'd0);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_parity",    32'(out_parity), 32'd0);
    check("rst_err",       32'(out_err),    32'd0);
    check("rst_ovf",       32'(out_ovf),    32'd0);
    check("rst_count",     32'(out_count),  32'd0);
    check("rst_state",     32'(state_dbg),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: single-word frames, all values, even mode, matching in_par
    for (int i = 0; i < 16; i++) begin
      d = 4'(i);
      send_beat(d, 1'b1, ^d, 1'b0);
      expect_result("single", ^d, 1'b0, 1'b0, 3'd1);
    end

    // 2: three-word odd-mode frame: p = 1^0^0 = 1, odd -> 0
    send_beat(4'b0001, 1'b0, 1'b0, 1'b1);
    send_beat(4'b0011, 1'b0, 1'b0, 1'b0);
    send_beat(4'b1111, 1'b1, 1'b0, 1'b0);
    expect_result("odd3", 1'b0, 1'b0, 1'b0, 3'd3);

    // 3: parity mismatch
    send_beat(4'b1011, 1'b1, 1'b0, 1'b0);
    expect_result("mism", 1'b1, 1'b1, 1'b0, 3'd1);

    // Boundary: exactly MAX_WORDS words, p = 0^1^0^1 = 0
    send_beat(4'b1111, 1'b0, 1'b0, 1'b0);
    send_beat(4'b0001, 1'b0, 1'b0, 1'b0);
    send_beat(4'b0000, 1'b0, 1'b0, 1'b0);
    send_beat(4'b0111, 1'b1, 1'b0, 1'b0);
    expect_result("full4", 1'b0, 1'b0, 1'b0, 3'd4);

    // 4: six words, overflow; first four give p = 1^1^0^1 = 1
    send_beat(4'b0001, 1'b0, 1'b0, 1'b0);
    send_beat(4'b0010, 1'b0, 1'b0, 1'b0);
    send_beat(4'b0011, 1'b0, 1'b0, 1'b0);
    send_beat(4'b0100, 1'b0, 1'b0, 1'b0);
    send_beat(4'b0101, 1'b0, 1'b0, 1'b0);
    check("ovf_no_early_valid", 32'(out_valid), 32'd0);
    send_beat(4'b0110, 1'b1, 1'b1, 1'b0);
    check("ovf_valid_next_cycle", 32'(out_valid), 32'd1);
    expect_result("ovf6", 1'b1, 1'b1, 1'b1, 3'd4);

    // 5: result held with out_ready low while in_valid stays high
    send_beat(4'b0111, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b0001;
    in_last  = 1'b1;
    in_par   = 1'b1;
    hold_par = out_parity;
    check("hold_parity_first", 32'(hold_par), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_valid",    32'(out_valid),  32'd1);
      check("hold_parity",   32'(out_parity), 32'(hold_par));
      check("hold_err",      32'(out_err),    32'd1);
      check("hold_count",    32'(out_count),  32'd1);
      check("hold_in_ready", 32'(in_ready),   32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_result("held", 1'b1, 1'b1, 1'b0, 3'd1);
    @(negedge clk);
    check("held_no_consume", 32'(out_valid), 32'd0);

    // 6: reset after two words of a frame
    send_beat(4'b0001, 1'b0, 1'b0, 1'b0);
    send_beat(4'b0011, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_state",     32'(state_dbg), 32'd0);
    check("midrst_count",     32'(out_count), 32'd0);
    send_beat(4'b0110, 1'b1, 1'b0, 1'b0);
    expect_result("after_rst", 1'b0, 1'b0, 1'b0, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
